// File: rtl/fifo_rd_stream_pkg.sv
// Shared definitions for the FIFO read-side streamer and the FIFO it drains.
package fifo_rd_stream_pkg;

  // Geometry of the team's synchronous FIFO.
  localparam int FIFO_DATA_W   = 16;
  localparam int FIFO_DEPTH    = 8;
  localparam int max_fifo_addr = $clog2(FIFO_DEPTH);

  // Output skid buffer holds exactly two words.
  localparam int SKID_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } rd_state_e;

endpackage

// File: rtl/fifo_rd_stream_rd_skid_buf.sv
// Two-entry register buffer between the FIFO read port and the output stream.
// The head entry is presented on head_data. Once the buffer drains, head_data
// keeps showing the last popped word rather than whatever stale entry the head
// pointer lands on.
module fifo_rd_stream_rd_skid_buf #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [1:0]       occupancy,
  output logic [WIDTH-1:0] head_data
);

  logic [WIDTH-1:0] mem [2];
  logic             head_ptr;
  logic             tail_ptr;
  logic [WIDTH-1:0] last_q;
  logic             pop_ok;
  logic             wr_ok;

  // A pop of an empty buffer is ignored.
  // A write into a full buffer only proceeds if a pop frees a slot in the same cycle.
  assign pop_ok = pop && (occupancy != 2'd0);
  assign wr_ok  = wr && ((occupancy != 2'd2) || pop_ok);

  // Pointer, occupancy and last-popped-word tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_ptr  <= 1'b0;
      tail_ptr  <= 1'b0;
      occupancy <= 2'd0;
      last_q    <= '0;
    end else begin
      if (wr_ok) tail_ptr <= ~tail_ptr;
      if (pop_ok) begin
        head_ptr <= ~head_ptr;
        last_q   <= mem[head_ptr];
      end
      case ({wr_ok, pop_ok})
        2'b10:   occupancy <= occupancy + 2'd1;
        2'b01:   occupancy <= occupancy - 2'd1;
        default: occupancy <= occupancy;
      endcase
    end
  end

  // Storage write at the tail slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (wr_ok) begin
      mem[tail_ptr] <= wr_data;
    end
  end

  assign head_data = (occupancy != 2'd0) ? mem[head_ptr] : last_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side consumer of the synchronous FIFO. Reads are issued against a
// credit count that covers buffered words plus the one read in flight. The
// FIFO has a one-cycle read latency, so the skid buffer can never overflow.
//
// state | meaning
// IDLE  | no reads issued; waiting for en
// RUN   | streaming; reads issued while credit is available
// STOP  | en dropped; no new reads, finishing in-flight and buffered words
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int FIFO_WIDTH = FIFO_DATA_W,
  parameter int BUF_DEPTH  = SKID_DEPTH,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  busy,
  output logic [CNT_W-1:0]      rd_count,
  output logic                  underflow_err
);

  rd_state_e   state;
  rd_state_e   state_nxt;
  logic        inflight;
  logic [1:0]  occupancy;
  logic        pop;
  logic [2:0]  credit_used;
  logic        credit_ok;

  assign m_valid = (occupancy != 2'd0);
  assign pop     = m_valid && m_ready;

  // Slots committed after this cycle: buffered + in flight - leaving now.
  // pop implies occupancy >= 1, so the result never goes negative.
  assign credit_used = {1'b0, occupancy} + {2'b00, inflight} - {2'b00, pop};
  assign credit_ok   = (credit_used < 3'(BUF_DEPTH));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state, read issue and busy decode.
  always_comb begin
    state_nxt  = state;
    fifo_rd_en = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (en) state_nxt = RUN;
      end
      RUN: begin
        fifo_rd_en = !fifo_empty && credit_ok;
        if (!en) state_nxt = STOP;
      end
      STOP: begin
        if (en)                                    state_nxt = RUN;
        else if (!inflight && (occupancy == 2'd0)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Tracks the single outstanding read; cleared by reset so a stale return is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inflight <= 1'b0;
    else        inflight <= fifo_rd_en;
  end

  // Delivered-word counter, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   rd_count <= '0;
    else if (pop) rd_count <= rd_count + CNT_W'(1);
  end

  // Sticky underflow flag; operation continues regardless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              underflow_err <= 1'b0;
    else if (fifo_underflow) underflow_err <= 1'b1;
  end

  fifo_rd_stream_rd_skid_buf #(
    .WIDTH (FIFO_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr        (inflight),
    .wr_data   (fifo_data_out),
    .pop       (pop),
    .occupancy (occupancy),
    .head_data (m_data)
  );

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a small behavioural FIFO model.
module tb_fifo_rd_stream;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          en = 1'b0;
  logic          fifo_underflow = 1'b0;
  logic          m_ready = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [W-1:0]  fifo_data_out = '0;
  logic          fifo_rd_en;
  logic          m_valid;
  logic [W-1:0]  m_data;
  logic          busy;
  logic [15:0]   rd_count;
  logic          underflow_err;

  logic [W-1:0]  fq[$];
  int            load_cnt = 0;
  logic          fifo_clr = 1'b0;

  int            n_chk = 0;
  int            n_fail = 0;
  int            exp_w;

  always #5 clk = ~clk;

  fifo_rd_stream #(
    .FIFO_WIDTH (W),
    .BUF_DEPTH  (2),
    .CNT_W      (16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en             (en),
    .fifo_empty     (fifo_empty),
    .fifo_underflow (fifo_underflow),
    .fifo_data_out  (fifo_data_out),
    .fifo_rd_en     (fifo_rd_en),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data),
    .busy           (busy),
    .rd_count       (rd_count),
    .underflow_err  (underflow_err)
  );

  // FIFO model: one-cycle read latency, loads words 1..load_cnt.
  always @(posedge clk) begin
    if (fifo_clr) fq.delete();
    for (int i = 1; i <= load_cnt; i++) fq.push_back(W'(i));
    if (fifo_rd_en && fq.size() != 0) fifo_data_out <= fq.pop_front();
    fifo_empty <= (fq.size() == 0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic load(input int n);
    @(negedge clk);
    fifo_clr = 1'b1;
    load_cnt = n;
    @(posedge clk);
    #1;
    fifo_clr = 1'b0;
    load_cnt = 0;
  endtask

  initial begin
    // Asynchronous reset before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_rd_en",    32'(fifo_rd_en),    32'd0);
    chk("rst_m_valid",  32'(m_valid),       32'd0);
    chk("rst_m_data",   32'(m_data),        32'd0);
    chk("rst_busy",     32'(busy),          32'd0);
    chk("rst_rd_count", 32'(rd_count),      32'd0);
    chk("rst_uf_err",   32'(underflow_err), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Full-rate drain of 8 words.
    load(8);
    @(negedge clk);
    en = 1'b1;
    m_ready = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      chk("full_rd_en",   32'(fifo_rd_en), 32'(i <= 8));
      chk("full_m_valid", 32'(m_valid),    32'(i >= 3 && i <= 10));
      if (i >= 3 && i <= 10) chk("full_m_data", 32'(m_data), 32'(i - 2));
    end
    chk("full_rd_count", 32'(rd_count), 32'd8);
    en = 1'b0;
    repeat (3) @(negedge clk);
    chk("full_idle_busy", 32'(busy), 32'd0);

    // Backpressure: 5 words, sink stalled.
    load(5);
    @(negedge clk);
    en = 1'b1;
    m_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk("bp_rd_en", 32'(fifo_rd_en), 32'(i <= 2));
      if (i >= 3) begin
        chk("bp_m_valid", 32'(m_valid), 32'd1);
        chk("bp_m_data",  32'(m_data),  32'd1);
      end
    end
    m_ready = 1'b1;
    exp_w = 1;
    for (int c = 0; c < 20 && exp_w <= 5; c++) begin
      if (c > 0) @(negedge clk);
      if (m_valid) begin
        chk("bp_order", 32'(m_data), 32'(exp_w));
        exp_w++;
      end
    end
    chk("bp_words", 32'(exp_w), 32'd6);
    @(negedge clk);
    chk("bp_rd_count", 32'(rd_count), 32'd13);
    chk("bp_fifo_empty", 32'(fifo_empty), 32'd1);
    en = 1'b0;
    repeat (3) @(negedge clk);
    chk("bp_idle_busy", 32'(busy), 32'd0);

    // Graceful stop after the third read.
    load(8);
    @(negedge clk);
    en = 1'b1;
    m_ready = 1'b1;
    exp_w = 1;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      chk("stop_rd_en", 32'(fifo_rd_en), 32'(i <= 3));
      if (m_valid) begin
        chk("stop_order", 32'(m_data), 32'(exp_w));
        exp_w++;
      end
      if (i == 3) en = 1'b0;
    end
    chk("stop_words",     32'(exp_w),     32'd4);
    chk("stop_busy",      32'(busy),      32'd0);
    chk("stop_fifo_left", 32'(fq.size()), 32'd5);
    chk("stop_rd_count",  32'(rd_count),  32'd16);

    // Sticky underflow.
    @(negedge clk);
    chk("uf_before", 32'(underflow_err), 32'd0);
    fifo_underflow = 1'b1;
    @(negedge clk);
    fifo_underflow = 1'b0;
    chk("uf_set", 32'(underflow_err), 32'd1);
    repeat (20) @(negedge clk);
    chk("uf_sticky", 32'(underflow_err), 32'd1);

    // Reset mid-operation with a word buffered and a read in flight.
    load(5);
    @(negedge clk);
    en = 1'b1;
    m_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_pre_valid", 32'(m_valid), 32'd1);
    chk("mid_pre_data",  32'(m_data),  32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_m_valid",  32'(m_valid),       32'd0);
    chk("mid_rd_count", 32'(rd_count),      32'd0);
    chk("mid_uf_err",   32'(underflow_err), 32'd0);
    chk("mid_busy",     32'(busy),          32'd0);
    chk("mid_rd_en",    32'(fifo_rd_en),    32'd0);
    chk("mid_m_data",   32'(m_data),        32'd0);
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mid_no_stale", 32'(m_valid), 32'd0);
    end
    en = 1'b1;
    exp_w = 3;
    for (int c = 0; c < 20 && exp_w <= 5; c++) begin
      @(negedge clk);
      if (m_valid) begin
        chk("mid_resume_order", 32'(m_data), 32'(exp_w));
        exp_w++;
      end
    end
    chk("mid_resume_words", 32'(exp_w), 32'd6);
    @(negedge clk);
    chk("mid_resume_count", 32'(rd_count), 32'd3);
    en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
